// File: rtl/led_scan_driver_pkg.sv
// Shared definitions for the LED scan driver: matrix row count, row index type
// and the per-row scan phase.
package snake_pkg;
    localparam int ROW_COUNT = 8;

    typedef logic [2:0] row_t;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;
endpackage

// File: rtl/led_scan_driver_if.sv
// Back-buffer write / swap bus plus the LED strobe outputs of led_scan_driver.
// The brightness input exists only when LED_SCAN_DIM_EN is defined.
interface led_scan_driver_if;
    logic       wr_en;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       swap_req;
    logic [7:0] led_col;
    logic [7:0] led_row;
    logic       frame_done;
    logic       swap_ack;
`ifdef LED_SCAN_DIM_EN
    logic [2:0] brightness;

    modport master (
        output wr_en, wr_row, wr_data, swap_req, brightness,
        input  led_col, led_row, frame_done, swap_ack
    );
    modport slave (
        input  wr_en, wr_row, wr_data, swap_req, brightness,
        output led_col, led_row, frame_done, swap_ack
    );
`else
    modport master (
        output wr_en, wr_row, wr_data, swap_req,
        input  led_col, led_row, frame_done, swap_ack
    );
    modport slave (
        input  wr_en, wr_row, wr_data, swap_req,
        output led_col, led_row, frame_done, swap_ack
    );
`endif
endinterface

// File: rtl/led_scan_driver_scan_timer.sv
// Row scan sequencer: BLANK then DRIVE phases per row, rows 0..7, with a strobe
// in the last DRIVE cycle of row 7. Next-cycle row/phase are exported so the
// parent can register its outputs in step with the phase.
module scan_timer
    import snake_pkg::*;
#(
    parameter int ROW_TICKS   = 16,
    parameter int BLANK_TICKS = 2
) (
    input  logic        clk,
    input  logic        reset,
    output row_t        row_next,
    output scan_state_t state_next,
    output logic        frame_end
);
    localparam int            TW         = $clog2(ROW_TICKS);
    localparam logic [TW-1:0] LAST_TICK  = TW'(ROW_TICKS - 1);
    localparam logic [TW-1:0] LAST_BLANK = TW'(BLANK_TICKS - 1);
    localparam row_t          LAST_ROW   = row_t'(ROW_COUNT - 1);

    logic [TW-1:0] tick_reg, tick_next;
    row_t          row_reg;
    scan_state_t   state_reg;

    // The tick counts across the whole row; the phase changes at fixed tick values.
    always_comb begin
        tick_next  = tick_reg + TW'(1);
        row_next   = row_reg;
        state_next = state_reg;
        case (state_reg)
            ST_BLANK: begin
                if (tick_reg == LAST_BLANK) state_next = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (tick_reg == LAST_TICK) begin
                    tick_next  = '0;
                    row_next   = row_reg + row_t'(1);
                    state_next = ST_BLANK;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_reg  <= '0;
            row_reg   <= '0;
            state_reg <= ST_BLANK;
        end else begin
            tick_reg  <= tick_next;
            row_reg   <= row_next;
            state_reg <= state_next;
        end
    end

    assign frame_end = (state_reg == ST_DRIVE) && (tick_reg == LAST_TICK) && (row_reg == LAST_ROW);
endmodule

// File: rtl/led_scan_driver.sv
// Double-buffered 8x8 LED matrix scanner: host writes the back buffer, a swap
// request publishes it at the next frame boundary. LED_SCAN_DIM_EN adds PWM brightness.
module led_scan_driver
    import snake_pkg::*;
#(
    parameter int ROW_TICKS   = 16,
    parameter int BLANK_TICKS = 2
) (
    input  logic               clk,
    input  logic               reset,
    led_scan_driver_if.slave   bus
);
    row_t        row_next;
    scan_state_t state_next;
    logic        frame_end;
    logic        swap_now;
    logic        drive_next;
    logic        pwm_on;
    logic        pending_reg;
    logic [7:0]  led_col_reg, led_row_reg;
    logic        frame_done_reg, swap_ack_reg;
    logic [7:0]  front_word [ROW_COUNT];

    scan_timer #(
        .ROW_TICKS   (ROW_TICKS),
        .BLANK_TICKS (BLANK_TICKS)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .row_next   (row_next),
        .state_next (state_next),
        .frame_end  (frame_end)
    );

    assign swap_now   = frame_end && pending_reg;
    assign drive_next = (state_next == ST_DRIVE);

    // Front copies the old back contents, so a coincident write lands in back only.
    for (genvar gi = 0; gi < ROW_COUNT; gi++) begin : g_row
        logic [7:0] back_reg, front_reg;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                back_reg  <= 8'h00;
                front_reg <= 8'h00;
            end else begin
                if (bus.wr_en && (bus.wr_row == row_t'(gi))) back_reg <= bus.wr_data;
                if (swap_now) front_reg <= back_reg;
            end
        end
        assign front_word[gi] = front_reg;
    end

`ifdef LED_SCAN_DIM_EN
    logic [2:0] pwm_reg, pwm_next;
    logic [3:0] pwm_limit;

    // A nonzero led_col_reg means the current cycle is DRIVE, so the count continues.
    always_comb begin
        pwm_next = 3'd0;
        if (drive_next && (led_col_reg != 8'h00)) pwm_next = pwm_reg + 3'd1;
    end

    assign pwm_limit = {1'b0, bus.brightness} + 4'd1;
    assign pwm_on    = ({1'b0, pwm_next} < pwm_limit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pwm_reg <= 3'd0;
        else       pwm_reg <= pwm_next;
    end
`else
    assign pwm_on = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_reg    <= 1'b0;
            led_col_reg    <= 8'h00;
            led_row_reg    <= 8'h00;
            frame_done_reg <= 1'b0;
            swap_ack_reg   <= 1'b0;
        end else begin
            // A request in the boundary cycle survives the clear and waits a frame.
            pending_reg    <= (pending_reg && !frame_end) || bus.swap_req;
            frame_done_reg <= frame_end;
            swap_ack_reg   <= swap_now;
            led_col_reg    <= drive_next ? (8'd1 << row_next) : 8'h00;
            led_row_reg    <= (drive_next && pwm_on) ? front_word[row_next] : 8'h00;
        end
    end

    assign bus.led_col    = led_col_reg;
    assign bus.led_row    = led_row_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.swap_ack   = swap_ack_reg;
endmodule

// File: doc/led_scan_driver.md
LED_SCAN_DRIVER -- requirements
Module: led_scan_driver

Interface
REQ-001 SHALL have parameter ROW_TICKS, default 16, meaning clock cycles per scanned row (min 4).
REQ-002 SHALL have parameter BLANK_TICKS, default 2, meaning cycles at row start with outputs blanked (1 <= BLANK_TICKS < ROW_TICKS).
REQ-003 SHALL have port clk  input  1  single system clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  write one row of the back buffer this cycle.
REQ-006 SHALL have port wr_row  input  3  back-buffer row index for the write.
REQ-007 SHALL have port wr_data  input  8  row pixel pattern for the write.
REQ-008 SHALL have port swap_req  input  1  single-cycle request to publish the back buffer at the next frame boundary.
REQ-009 SHALL have port led_col  output  8  one-hot row-select strobe.
REQ-010 SHALL have port led_row  output  8  pixel pattern for the selected row.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at each frame boundary.
REQ-012 SHALL have port swap_ack  output  1  one-cycle pulse when a pending swap is applied.

Function
REQ-013 SHALL hold two 8x8-bit buffers: front (displayed) and back (written).
REQ-014 SHALL write wr_data into back[wr_row] on a clock edge with wr_en=1; front is never written directly.
REQ-015 SHALL run FSM states BLANK and DRIVE per row: BLANK for BLANK_TICKS cycles, then DRIVE for ROW_TICKS-BLANK_TICKS cycles, then BLANK of the next row.
REQ-016 SHALL advance row index 0..7, wrapping 7->0 at the end of DRIVE for row 7 (frame boundary); frame period = 8*ROW_TICKS cycles.
REQ-017 SHALL drive registered outputs: in DRIVE, led_col = 1<<row and led_row = front[row]; in BLANK, both are 8'h00.
REQ-018 SHALL latch swap_req into a pending flag; repeated requests before the boundary collapse into one.
REQ-019 SHALL, at the frame boundary with pending set: copy back into front, clear pending, and pulse swap_ack with frame_done in the same cycle.
REQ-020 SHALL, when wr_en coincides with the boundary copy, land the write in back only; front receives the pre-write back contents.
REQ-021 SHALL, when swap_req arrives in the boundary cycle itself, defer it to the next boundary.
REQ-022 SHALL keep displayed data stable within a frame; back-buffer writes never alter led_row mid-frame.

Reset
REQ-023 SHALL on reset assertion, asynchronously and regardless of clk: row=0, state BLANK, tick counter 0, both buffers 0, pending 0, all outputs 0.
REQ-024 SHALL, after reset deassertion, start the first row in BLANK; first DRIVE cycle with led_col=8'h01 appears BLANK_TICKS cycles later.
REQ-025 SHALL, on reset mid-frame, discard any pending swap and buffered data.

Configuration
REQ-026 SHALL compile a brightness feature under macro LED_SCAN_DIM_EN.
REQ-027 With LED_SCAN_DIM_EN: add input brightness (3 bits); a 3-bit PWM counter increments each DRIVE cycle and clears in BLANK; led_row = front[row] while pwm < brightness+1, else 8'h00; led_col stays asserted.
REQ-028 Without LED_SCAN_DIM_EN: no brightness port; behaviour equals brightness=7 (full on throughout DRIVE).

Structure
REQ-029 SHALL place ROW_COUNT=8, the 3-bit row index type and the BLANK/DRIVE state enum in shared package snake_pkg.
REQ-030 SHALL use one sub-module, scan_timer, producing the tick count, row index, phase and frame-boundary strobe; buffers and output regs stay in led_scan_driver.

Verification
REQ-031 Reset, write 8'hA5 to back row 3, no swap -> led_row stays 8'h00 for two full frames (256 cycles).
REQ-032 Write 8'hA5 to row 3, pulse swap_req -> swap_ack+frame_done at the next boundary; the following frame shows led_col=8'h08, led_row=8'hA5 for 14 cycles, 8'h00 for 2 blank cycles.
REQ-033 Three swap_req pulses in one frame -> exactly one swap_ack; swap_req in a boundary cycle -> swap_ack one frame (128 cycles) later.
REQ-034 wr_en row 0 = 8'hFF in the boundary cycle of a swap, with back row 0 previously 8'h11 -> front row 0 shows 8'h11; next swap shows 8'hFF.
REQ-035 Assert reset during DRIVE of row 5 -> outputs 8'h00 immediately (no clk edge); after release, first drive led_col=8'h01 after 2 cycles.
REQ-036 With LED_SCAN_DIM_EN, brightness=1, front row 0 = 8'hFF -> within each DRIVE phase led_row=8'hFF exactly 2 of every 8 cycles.
